// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Holds the FSM state encoding and the bit-counter sizing function.
package serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // One extra bit keeps the counter legal when width is 1 ($clog2(1) == 0).
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder composed of two half-adder stages and an OR gate.
// This is the only arithmetic cell in the serial adder datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    // First half adder: a + b
    assign ha0_s = a ^ b;
    assign ha0_c = a & b;

    // Second half adder: partial sum + cin
    assign s     = ha0_s ^ cin;
    assign ha1_c = ha0_s & cin;

    assign co = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flop, one bit per clock.
// Operands are captured on an accepted start; the result lands after WIDTH RUN cycles.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] ps_shift;
    logic             last;

    full_adder u_full_adder (
        .a   (sa_q[0]),
        .b   (sb_q[0]),
        .cin (c_q),
        .s   (s_bit),
        .co  (c_next)
    );

    // Partial sum with the current bit entering at the MSB; valid for WIDTH == 1 too.
    always_comb begin
        ps_shift = ps_q >> 1;
        ps_shift[WIDTH-1] = s_bit;
    end

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ps_d    = ps_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sa_d    = a;
                    sb_d    = b;
                    ps_d    = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                c_d   = c_next;
                ps_d  = ps_shift;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    sum_d   = ps_shift;
                    cout_d  = c_next;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ps_q    <= ps_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
